// File: rtl/rr_mux_8x1_stream_if.sv
// Stream bundle for the 8:1 round-robin merger: eight valid/ready/last
// sources on the input side, one tagged valid/ready/last stream out.
interface rr_mux_8x1_stream_if #(
    parameter int W = 8
);
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_last;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_last;
    logic           out_ready;

    // Upstream sources and downstream sink as seen from the environment
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    // The merger itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/rr_mux_8x1_stream.sv
// 8:1 round-robin stream merger with optional packet locking.
// One registered output stage, tagged with the source channel index so a
// downstream 1x8 demux can steer the beat back using out_sel.
module rr_mux_8x1_stream #(
    parameter int W       = 8,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_mux_8x1_stream_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   lock_ch_q, lock_ch_d;

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic [2:0]   out_sel_q;
    logic         out_last_q;

    logic         load;
    logic [7:0]   req_rot;
    logic [2:0]   off;
    logic [2:0]   win;
    logic [2:0]   ch;
    logic [7:0]   grant;
    logic [7:0]   ready;
    logic         xfer;
    logic [W-1:0] ch_data;

    // Output register can take a new beat when empty or retiring this cycle
    assign load = ~out_valid_q | bus.out_ready;

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit
    always_comb begin
        req_rot = 8'h00;
        off     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            req_rot[i] = bus.in_valid[ptr_q + 3'(i)];
        end
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) off = 3'(i);
        end
        win = ptr_q + off;
    end

    // Grant: the locked channel alone while a packet is open, else the RR winner
    always_comb begin
        grant = 8'h00;
        ch    = win;
        if (state_q == LOCKED) begin
            grant[lock_ch_q] = 1'b1;
            ch               = lock_ch_q;
        end else if (|bus.in_valid) begin
            grant[win] = 1'b1;
        end
    end

    // Payload select for the granted channel
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (ch == 3'(i)) ch_data = bus.in_data[i*W +: W];
        end
    end

    // rst_n gating keeps every source held off while the block is in reset
    assign ready        = grant & {8{load}} & {8{rst_n}};
    assign xfer         = |(ready & bus.in_valid);
    assign bus.in_ready = ready;

    // Arbitration FSM next-state: pointer advances only on unlocked wins
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_ch_d = lock_ch_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    ptr_d = win + 3'd1;
                    if (LOCK_EN && !bus.in_last[win]) begin
                        state_d   = LOCKED;
                        lock_ch_d = win;
                    end
                end
            end
            LOCKED: begin
                if (xfer && bus.in_last[lock_ch_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            lock_ch_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Output stage: capture on transfer, hold on stall, drop valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 3'd0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ch_data;
            out_sel_q   <= ch;
            out_last_q  <= bus.in_last[ch];
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_rr_mux_8x1_stream.sv
// Bench for rr_mux_8x1_stream: one locking and one non-locking instance,
// each with its own stimulus, compared cycle by cycle with a queue-free
// behavioural model of the arbitration rules plus directed expectations.
module tb_rr_mux_8x1_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux_8x1_stream_if #(.W(8)) bus_l ();
    rr_mux_8x1_stream_if #(.W(8)) bus_n ();

    rr_mux_8x1_stream #(.W(8), .LOCK_EN(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    rr_mux_8x1_stream #(.W(8), .LOCK_EN(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    // Per-instance stimulus (index 0 = locking, 1 = non-locking)
    logic [7:0]  iv [2];
    logic [63:0] id [2];
    logic [7:0]  il [2];
    logic        ordy [2];

    assign bus_l.in_valid  = iv[0];
    assign bus_l.in_data   = id[0];
    assign bus_l.in_last   = il[0];
    assign bus_l.out_ready = ordy[0];
    assign bus_n.in_valid  = iv[1];
    assign bus_n.in_data   = id[1];
    assign bus_n.in_last   = il[1];
    assign bus_n.out_ready = ordy[1];

    // Reference model state
    int         m_ptr [2];
    bit         m_locked [2];
    int         m_lock [2];
    logic       m_ov [2];
    logic [7:0] m_od [2];
    int         m_os [2];
    logic       m_ol [2];

    int passed = 0;
    int total  = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_locked[m] = 0; m_lock[m] = 0;
            m_ov[m] = 1'b0; m_od[m] = 8'h00; m_os[m] = 0; m_ol[m] = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_ready(int m);
        logic [7:0] g;
        int c;
        g = 8'h00;
        if (!rst_n) return 8'h00;
        if (m_ov[m] && !ordy[m]) return 8'h00;
        if (m_locked[m]) begin
            g[m_lock[m]] = 1'b1;
        end else begin
            for (int j = 0; j < 8; j++) begin
                c = (m_ptr[m] + j) % 8;
                if (iv[m][c]) begin
                    g[c] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic model_update();
        logic [7:0] r;
        logic [7:0] x;
        int k;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_ptr[m] = 0; m_locked[m] = 0; m_lock[m] = 0;
                m_ov[m] = 1'b0; m_od[m] = 8'h00; m_os[m] = 0; m_ol[m] = 1'b0;
            end else begin
                r = model_ready(m);
                x = r & iv[m];
                if (x != 8'h00) begin
                    k = 0;
                    for (int j = 0; j < 8; j++) if (x[j]) k = j;
                    m_ov[m] = 1'b1;
                    m_od[m] = id[m][k*8 +: 8];
                    m_os[m] = k;
                    m_ol[m] = il[m][k];
                    if (m_locked[m]) begin
                        if (il[m][k]) m_locked[m] = 0;
                    end else begin
                        m_ptr[m] = (k + 1) % 8;
                        if (m == 0 && !il[m][k]) begin
                            m_locked[m] = 1;
                            m_lock[m]   = k;
                        end
                    end
                end else if (!m_ov[m] || ordy[m]) begin
                    m_ov[m] = 1'b0;
                end
            end
        end
    endtask

    // Observation vectors: payload fields only matter while out_valid is set
    function automatic logic [20:0] dut_obs(int m);
        logic v; logic [2:0] s; logic l; logic [7:0] d; logic [7:0] r;
        if (m == 0) begin
            v = bus_l.out_valid; s = bus_l.out_sel; l = bus_l.out_last; d = bus_l.out_data; r = bus_l.in_ready;
        end else begin
            v = bus_n.out_valid; s = bus_n.out_sel; l = bus_n.out_last; d = bus_n.out_data; r = bus_n.in_ready;
        end
        return (v === 1'b1) ? {1'b1, s, l, d, r} : {v, 12'h000, r};
    endfunction

    function automatic logic [20:0] model_obs(int m);
        logic [7:0] r;
        r = model_ready(m);
        return m_ov[m] ? {1'b1, 3'(m_os[m]), m_ol[m], m_od[m], r} : {1'b0, 12'h000, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            iv[m] = 8'h00; il[m] = 8'h00; id[m] = 64'h0; ordy[m] = 1'b1;
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            iv[m] = 8'hFF; il[m] = 8'hFF; id[m] = 64'h0; ordy[m] = 1'b1;
        end
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({bus_l.out_valid, bus_l.out_sel, bus_l.out_last, bus_l.out_data, bus_l.in_ready} !== 21'h0)
                $display("FAIL reset_lock cyc%0d got=%b/%0d/%b/%h rdy=%h want all zero", c,
                         bus_l.out_valid, bus_l.out_sel, bus_l.out_last, bus_l.out_data, bus_l.in_ready);
            else passed++;
            total++;
            if ({bus_n.out_valid, bus_n.out_sel, bus_n.out_last, bus_n.out_data, bus_n.in_ready} !== 21'h0)
                $display("FAIL reset_nolock cyc%0d got=%b/%0d/%b/%h rdy=%h want all zero", c,
                         bus_n.out_valid, bus_n.out_sel, bus_n.out_last, bus_n.out_data, bus_n.in_ready);
            else passed++;
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        logic [20:0] g;
        for (int m = 0; m < 2; m++) begin
            iv[m] = 8'hFF; il[m] = 8'hFF; ordy[m] = 1'b1;
            for (int i = 0; i < 8; i++) id[m][i*8 +: 8] = 8'(16 + i);
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (dut_obs(m) !== model_obs(m))
                    $display("FAIL fairness_model dut%0d cyc%0d got=%h want=%h", m, c, dut_obs(m), model_obs(m));
                else passed++;
            end
            if (c >= 1) begin
                g = dut_obs(0);
                total++;
                if (bus_l.out_valid !== 1'b1 || bus_l.out_sel !== 3'((c - 1) % 8) || bus_l.out_data !== 8'(16 + (c - 1) % 8))
                    $display("FAIL fairness_order cyc%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h (obs %h)",
                             c, bus_l.out_valid, bus_l.out_sel, bus_l.out_data, (c - 1) % 8, 16 + (c - 1) % 8, g);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        for (int m = 0; m < 2; m++) begin
            iv[m] = 8'h00; ordy[m] = 1'b1; il[m] = 8'hFF;
        end
        for (int c = 0; c < 8; c++) begin
            for (int m = 0; m < 2; m++) begin
                id[m] = 64'h0;
                id[m][5*8 +: 8] = 8'hA5;
                id[m][1*8 +: 8] = 8'h11;
                if (c < 2)       begin iv[m] = 8'h00; ordy[m] = 1'b1; end
                else if (c == 2) begin iv[m] = 8'h20; ordy[m] = 1'b0; end
                else if (c < 6)  begin iv[m] = 8'h02; ordy[m] = 1'b0; end
                else if (c == 6) begin iv[m] = 8'h02; ordy[m] = 1'b1; end
                else             begin iv[m] = 8'h00; ordy[m] = 1'b1; end
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (dut_obs(m) !== model_obs(m))
                    $display("FAIL stall_model dut%0d cyc%0d got=%h want=%h", m, c, dut_obs(m), model_obs(m));
                else passed++;
            end
            if (c >= 3 && c <= 6) begin
                total++;
                if (bus_l.out_valid !== 1'b1 || bus_l.out_sel !== 3'd5 || bus_l.out_data !== 8'hA5 ||
                    bus_l.in_ready !== ((c == 6) ? 8'h02 : 8'h00))
                    $display("FAIL stall_hold cyc%0d got v=%b sel=%0d data=%h rdy=%h want v=1 sel=5 data=a5 rdy=%h",
                             c, bus_l.out_valid, bus_l.out_sel, bus_l.out_data, bus_l.in_ready, (c == 6) ? 8'h02 : 8'h00);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_packet(input bit bubble);
        int beat [2];
        int gap [2];
        logic [7:0] r [2];
        int seq0 [$];
        int seq1 [$];
        int exp0 [4];
        int exp1 [4];
        int idle_l;
        int oc;
        bit ok;
        string nm;
        oc = bubble ? 6 : 3;
        nm = bubble ? "bubble" : "lock";
        exp0 = bubble ? '{2, 2, 2, 6} : '{2, 2, 2, 3};
        exp1 = '{2, 3, 2, 3};
        do_reset();
        beat = '{0, 0};
        gap  = '{0, 0};
        idle_l = 0;
        for (int c = 0; c < 8; c++) begin
            for (int m = 0; m < 2; m++) begin
                iv[m] = 8'h00; il[m] = 8'hFF; id[m] = 64'h0; ordy[m] = 1'b1;
                iv[m][2] = (beat[m] < 3 && gap[m] == 0);
                id[m][2*8 +: 8] = 8'(32 + beat[m]);
                il[m][2] = (beat[m] == 2);
                iv[m][oc] = 1'b1;
                id[m][oc*8 +: 8] = 8'(16 * oc);
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (dut_obs(m) !== model_obs(m))
                    $display("FAIL %s_model dut%0d cyc%0d got=%h want=%h", nm, m, c, dut_obs(m), model_obs(m));
                else passed++;
                r[m] = model_ready(m);
            end
            if (beat[0] > 0 && beat[0] < 3) begin
                total++;
                if (bus_l.in_ready[oc] !== 1'b0)
                    $display("FAIL %s_other_held cyc%0d in_ready=%h want bit %0d low", nm, c, bus_l.in_ready, oc);
                else passed++;
            end
            if (c >= 1 && c <= 6) begin
                if (bus_l.out_valid === 1'b1) seq0.push_back(int'(bus_l.out_sel));
                else idle_l++;
                if (bus_n.out_valid === 1'b1) seq1.push_back(int'(bus_n.out_sel));
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (r[m][2] && iv[m][2]) begin
                    beat[m]++;
                    if (bubble && beat[m] == 1) gap[m] = 2;
                end else if (gap[m] > 0) begin
                    gap[m]--;
                end
            end
        end
        ok = (seq0.size() >= 4);
        for (int i = 0; i < 4; i++) if (ok && seq0[i] != exp0[i]) ok = 0;
        total++;
        if (!ok) $display("FAIL %s_order_lock got=%p want=%p", nm, seq0, exp0);
        else passed++;
        total++;
        if (idle_l != (bubble ? 2 : 0))
            $display("FAIL %s_idle_cycles got=%0d want=%0d", nm, idle_l, bubble ? 2 : 0);
        else passed++;
        if (!bubble) begin
            ok = (seq1.size() >= 4);
            for (int i = 0; i < 4; i++) if (ok && seq1[i] != exp1[i]) ok = 0;
            total++;
            if (!ok) $display("FAIL %s_order_nolock got=%p want=%p", nm, seq1, exp1);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int m = 0; m < 2; m++) begin
                iv[m] = 8'h04; il[m] = 8'h00; id[m] = 64'h0;
                id[m][2*8 +: 8] = 8'(8'h2A + c);
                ordy[m] = (c == 0);
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (dut_obs(m) !== model_obs(m))
                    $display("FAIL arst_pre dut%0d cyc%0d got=%h want=%h", m, c, dut_obs(m), model_obs(m));
                else passed++;
            end
            if (c == 0) tick();
        end
        total++;
        if (bus_l.out_valid !== 1'b1) $display("FAIL arst_setup out_valid=%b want 1", bus_l.out_valid);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (bus_l.out_valid !== 1'b0 || bus_l.in_ready !== 8'h00 || bus_n.out_valid !== 1'b0 || bus_n.in_ready !== 8'h00)
            $display("FAIL arst_immediate got v=%b/%b rdy=%h/%h want v=0 rdy=00",
                     bus_l.out_valid, bus_n.out_valid, bus_l.in_ready, bus_n.in_ready);
        else passed++;
        tick();
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            iv[m] = 8'h60; il[m] = 8'hFF; id[m] = 64'h0; ordy[m] = 1'b1;
            id[m][5*8 +: 8] = 8'h55;
            id[m][6*8 +: 8] = 8'h66;
        end
        #1;
        total++;
        if (bus_l.in_ready !== 8'h20 || bus_n.in_ready !== 8'h20)
            $display("FAIL arst_first_grant in_ready=%h/%h want 20", bus_l.in_ready, bus_n.in_ready);
        else passed++;
        tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            total++;
            if (dut_obs(m) !== model_obs(m))
                $display("FAIL arst_post dut%0d got=%h want=%h", m, dut_obs(m), model_obs(m));
            else passed++;
        end
        total++;
        if (bus_l.out_valid !== 1'b1 || bus_l.out_sel !== 3'd5 || bus_l.out_data !== 8'h55)
            $display("FAIL arst_first_beat got v=%b sel=%0d data=%h want v=1 sel=5 data=55",
                     bus_l.out_valid, bus_l.out_sel, bus_l.out_data);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] r [2];
        logic [7:0] acc [2];
        do_reset();
        acc = '{8'h00, 8'h00};
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                for (int ch = 0; ch < 8; ch++) begin
                    if (!iv[m][ch] || acc[m][ch]) begin
                        iv[m][ch] = ($urandom_range(0, 9) < 6);
                        id[m][ch*8 +: 8] = 8'($urandom);
                        il[m][ch] = ($urandom_range(0, 2) == 0);
                    end
                end
                ordy[m] = ($urandom_range(0, 9) < 7);
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (dut_obs(m) !== model_obs(m))
                    $display("FAIL random dut%0d cyc%0d got=%h want=%h", m, c, dut_obs(m), model_obs(m));
                else passed++;
                r[m] = model_ready(m);
            end
            tick();
            for (int m = 0; m < 2; m++) acc[m] = r[m] & iv[m];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_fairness();
        test_stall();
        test_packet(1'b0);
        test_packet(1'b1);
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
